// File: rtl/mac_lane_engine_pkg.sv
// mac_lane_engine_pkg
// Shared definitions for the MAC lane engine: FSM state encoding, lane and
// tap geometry, and the default accumulator width.
//   LANES     : number of parallel X lanes
//   TAPS      : bytes per lane, one coefficient per byte (one CALC pass)
//   BYTE_W    : X byte and coefficient width
//   ACC_W_DEF : 8x8 product plus 3 growth bits for 8 terms
package mac_lane_engine_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int LANES     = 4;
  localparam int TAPS      = 8;
  localparam int BYTE_W    = 8;
  localparam int ACC_W_DEF = 19;

endpackage

// File: rtl/mac_lane_engine_mac_lane.sv
// mac_lane
// One lane of unsigned 8x8 multiply-accumulate. The accumulator always runs
// at full ACC_W; the result register captures the final sum of a column.
// Build option: SAT_OUT_EN clamps the captured result to 16'hFFFF for a
// 16-bit consumer. Without it the result is the accumulator value unmodified.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   clr        : zero the accumulator (start of a column)
//   en         : add x*coef into the accumulator
//   load       : capture acc + x*coef into res (last tap of a column)
//   x, coef    : unsigned operands
//   res        : registered column result
module mac_lane
  import mac_lane_engine_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              load,
  input  logic [BYTE_W-1:0] x,
  input  logic [BYTE_W-1:0] coef,
  output logic [ACC_W-1:0]  res
);

  logic [2*BYTE_W-1:0] prod;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_sum;
  logic [ACC_W-1:0]    res_d;

  assign prod    = x * coef;
  assign acc_sum = acc + ACC_W'(prod);

`ifdef SAT_OUT_EN
  assign res_d = (acc_sum > ACC_W'(16'hFFFF)) ? ACC_W'(16'hFFFF) : acc_sum;
`else
  assign res_d = acc_sum;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_sum;
    end
  end

  // The result is taken from the sum of the final tap, so it is ready in the
  // same cycle the FSM enters OUT and holds through IDLE and the next CALC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res <= '0;
    end else if (load) begin
      res <= res_d;
    end
  end

endmodule

// File: rtl/mac_lane_engine.sv
// mac_lane_engine
// Walks a full 4x8 X block held in the shift buffer, multiplying each lane
// head byte by a shared ROM coefficient and accumulating per lane. Each
// column is an 8-shift pass that fully rotates the X buffer back to its
// starting phase; four results per column leave over a valid/ready handshake.
// Build option: SAT_OUT_EN (see mac_lane) saturates results to 16 bits.
// Ports:
//   clk, rst             : clock, asynchronous active-low reset
//   start, xload_done    : block request, accepted only when the buffer is full
//   X_reg1..X_reg4       : lane head bytes from the X buffer
//   coef_in / coef_addr  : combinational coefficient ROM, address {col, k}
//   x_shift              : rotate request to the X buffer (CALC only)
//   res1..res4           : lane results, res_valid / res_ready handshake
//   busy                 : engine not idle
//   block_done           : one-cycle pulse after the last column is accepted
//
// state | meaning
// IDLE  | waiting for start with a loaded X block
// CALC  | one tap per cycle, 8 cycles per column, X buffer rotating
// OUT   | column results presented, waiting for res_ready
module mac_lane_engine
  import mac_lane_engine_pkg::*;
#(
  parameter int NUM_COLS = 4,
  parameter int ACC_W    = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              xload_done,
  input  logic [BYTE_W-1:0] X_reg1,
  input  logic [BYTE_W-1:0] X_reg2,
  input  logic [BYTE_W-1:0] X_reg3,
  input  logic [BYTE_W-1:0] X_reg4,
  input  logic [BYTE_W-1:0] coef_in,
  output logic              x_shift,
  output logic [4:0]        coef_addr,
  output logic [ACC_W-1:0]  res1,
  output logic [ACC_W-1:0]  res2,
  output logic [ACC_W-1:0]  res3,
  output logic [ACC_W-1:0]  res4,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic              block_done
);

  localparam logic [1:0] LAST_COL = 2'(NUM_COLS - 1);
  localparam logic [2:0] LAST_K   = 3'(TAPS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        col;
  logic [2:0]        k;
  logic              acc_clr;
  logic              acc_en;
  logic              res_load;
  logic              accept;
  logic              last_col;
  logic [BYTE_W-1:0] x_lane   [LANES];
  logic [ACC_W-1:0]  res_lane [LANES];

  assign x_lane[0] = X_reg1;
  assign x_lane[1] = X_reg2;
  assign x_lane[2] = X_reg3;
  assign x_lane[3] = X_reg4;

  assign res1 = res_lane[0];
  assign res2 = res_lane[1];
  assign res3 = res_lane[2];
  assign res4 = res_lane[3];

  assign last_col  = (col == LAST_COL);
  assign coef_addr = {col, k};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    x_shift   = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    res_load  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start && xload_done) begin
          acc_clr   = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        busy    = 1'b1;
        x_shift = 1'b1;
        acc_en  = 1'b1;
        if (k == LAST_K) begin
          res_load  = 1'b1;
          state_nxt = OUT;
        end
      end
      OUT: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) begin
          accept = 1'b1;
          if (last_col) begin
            state_nxt = IDLE;
          end else begin
            acc_clr   = 1'b1;
            state_nxt = CALC;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // col returns to 0 at block end so coef_addr idles at 0; k wraps to 0
  // naturally after the eighth tap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col        <= '0;
      k          <= '0;
      block_done <= 1'b0;
    end else begin
      block_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && xload_done) begin
            col <= '0;
            k   <= '0;
          end
        end
        CALC: k <= k + 3'd1;
        OUT: begin
          if (accept) begin
            if (last_col) begin
              col        <= '0;
              block_done <= 1'b1;
            end else begin
              col <= col + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane #(
      .ACC_W(ACC_W)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .clr  (acc_clr),
      .en   (acc_en),
      .load (res_load),
      .x    (x_lane[i]),
      .coef (coef_in),
      .res  (res_lane[i])
    );
  end

endmodule
